pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the payload width (alu result, write data, pc+4 and similar fields packed by the instantiating stage).
REQ-002 The block SHALL have parameter CTRL_W, default 4, giving the control-bit width (reg_write, mem_write, result_src and similar), zeroed on bubble or flush.
REQ-003 The block SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous kill of all held entries.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream entry valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the stage accepts an entry this cycle.
REQ-008 The block SHALL have port in_ctrl, input, CTRL_W bits: upstream control bits.
REQ-009 The block SHALL have port in_data, input, DATA_W bits: upstream payload.
REQ-010 The block SHALL have port out_valid, output, 1 bit: an entry is presented downstream.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream stage accepts, acting as stall when low.
REQ-012 The block SHALL have port out_ctrl, output, CTRL_W bits: control bits of the presented entry.
REQ-013 The block SHALL have port out_data, output, DATA_W bits: payload of the presented entry.
REQ-014 The block SHALL have port count, output, 2 bits: number of held entries (0..2).

Function
REQ-015 Input fire SHALL be in_valid && in_ready; output fire SHALL be out_valid && out_ready.
REQ-016 The main register SHALL drive out_valid, out_ctrl and out_data directly from flops, with no combinational path from any input to these outputs.
REQ-017 Latency SHALL be 1 cycle: an entry accepted at edge N, with the stage empty, SHALL be presented from edge N+1.
REQ-018 Entries SHALL leave in acceptance order, and no entry SHALL be duplicated or dropped except by flush or rst.
REQ-019 out_ctrl SHALL be all-zero whenever out_valid=0, so that a bubble is a NOP; out_data SHALL hold its last value when invalid.
REQ-020 On output fire with a simultaneous input fire (single-entry path), the main register SHALL load the new entry with no bubble, giving full throughput.
REQ-021 When out_valid=1 and out_ready=0 with no input fire, the main register SHALL hold all fields unchanged.
REQ-022 When flush=1 at an edge, all valid bits SHALL clear, any same-cycle input fire SHALL be discarded, out_ctrl SHALL be zeroed, and count SHALL become 0.
REQ-023 rst SHALL take priority over flush, and flush SHALL take priority over all data movement.
REQ-024 count SHALL equal the number of valid flops (main plus skid) after each edge.

Reset
REQ-025 When rst=1 at a clock edge, out_valid, the skid valid, out_ctrl, out_data and count SHALL all become 0, and in_ready SHALL be 1 from the next cycle.
REQ-026 An rst asserted mid-transfer SHALL discard all held entries, and no entry accepted in the rst cycle SHALL survive.

Configuration
REQ-027 Macro PIPE_STAGE_SKID_EN SHALL select the stage structure.
REQ-028 When PIPE_STAGE_SKID_EN is undefined, there SHALL be a single register, count SHALL not exceed 1, and in_ready SHALL equal !out_valid || out_ready (combinational).
REQ-029 When PIPE_STAGE_SKID_EN is defined, a second skid register SHALL be added and in_ready SHALL equal !skid_valid, taken from a flop with no combinational path from out_ready.
REQ-030 When PIPE_STAGE_SKID_EN is defined and the main register is full, out_ready=0 and an input fire occurs, the entry SHALL go to the skid register and count SHALL become 2.
REQ-031 When PIPE_STAGE_SKID_EN is defined and the skid register is full with out_ready=1, the skid entry SHALL move to main and in_ready SHALL return to 1 next cycle.
REQ-032 When PIPE_STAGE_SKID_EN is defined and the main register is full, out_ready=1 and an input fire occurs with the skid empty, the input SHALL load into main directly.

Verification
REQ-033 Streaming: in_valid=1 with in_data=1,2,3,4 on consecutive cycles and out_ready=1 -> out_data=1,2,3,4 on edges N+1..N+4 with no bubble.
REQ-034 Stall: hold out_ready=0 while presenting 0xA then 0xB -> without skid, 0xA is held and in_ready=0; with skid, count=2 and in_ready=0; releasing out_ready then yields 0xA followed by 0xB.
REQ-035 Flush: with count=2 and in_ctrl=4'hF, flush=1 together with an input fire -> next cycle out_valid=0, out_ctrl=0, count=0, and the flushed-cycle input never appears.
REQ-036 Reset mid-stall: with count=1 and out_data=0xDEAD, assert rst together with flush -> out_valid=0, out_data=0, count=0, and in_ready=1 the following cycle.
REQ-037 Random: random in_valid/out_ready for 10k cycles checked against a reference queue -> order preserved, no loss, out_ctrl=0 whenever out_valid=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Pipeline stage register with valid/ready flow control, synchronous flush and
// bubble-as-NOP control zeroing. The payload (DATA_W) holds its last value
// when the stage is empty. The control bits (CTRL_W) are forced to zero when
// the stage is empty, so a bubble reaches downstream as a NOP.
//
// Build option (macro PIPE_STAGE_SKID_EN):
//   undefined : single main register. in_ready = !out_valid || out_ready is
//               combinational from out_ready. count is 0..1.
//   defined   : main register plus one skid register. in_ready = !skid_valid
//               comes straight from a flop, which cuts the ready path.
//               count is 0..2.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Upstream may not withdraw or change an offered entry until it has been
// accepted. out_valid/out_ctrl/out_data come straight from flops.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset (has priority over flush)
//   flush     in   synchronous kill of all held entries and any same-cycle input
//   in_valid  in   upstream entry valid
//   in_ready  out  stage accepts an entry this cycle
//   in_ctrl   in   [CTRL_W] upstream control bits
//   in_data   in   [DATA_W] upstream payload
//   out_valid out  entry presented downstream
//   out_ready in   downstream accepts (stall when low)
//   out_ctrl  out  [CTRL_W] control of presented entry, zero when invalid
//   out_data  out  [DATA_W] payload of presented entry, holds when invalid
//   count     out  [2] number of held entries
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    // Main register.
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] data_q,  data_d;

    logic in_fire;
    logic out_fire;

    assign out_valid = valid_q;
    assign out_ctrl  = ctrl_q;
    assign out_data  = data_q;
    assign out_fire  = valid_q && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    // Skid register. It is only ever full while main is full and stalled.
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;

    assign in_ready = !skid_valid_q;
    assign in_fire  = in_valid && in_ready;
    assign count    = {1'b0, valid_q} + {1'b0, skid_valid_q};

    always_comb begin
        valid_d      = valid_q;
        ctrl_d       = ctrl_q;
        data_d       = data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            valid_d      = 1'b0;
            ctrl_d       = '0;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
        end else if (skid_valid_q) begin
            // in_ready is low here, so only the drain of skid into main matters.
            if (out_ready) begin
                valid_d      = 1'b1;
                ctrl_d       = skid_ctrl_q;
                data_d       = skid_data_q;
                skid_valid_d = 1'b0;
                skid_ctrl_d  = '0;
            end
        end else if (in_fire) begin
            if (!valid_q || out_ready) begin
                valid_d = 1'b1;
                ctrl_d  = in_ctrl;
                data_d  = in_data;
            end else begin
                // Main is stalled: park the entry in skid.
                skid_valid_d = 1'b1;
                skid_ctrl_d  = in_ctrl;
                skid_data_d  = in_data;
            end
        end else if (out_fire) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
        end
    end
`else
    assign in_ready = !valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign count    = {1'b0, valid_q};

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (in_fire) begin
            // This covers a simultaneous output fire too, so there is no bubble.
            valid_d = 1'b1;
            ctrl_d  = in_ctrl;
            data_d  = in_data;
        end else if (out_fire) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;
`ifdef PIPE_STAGE_SKID_EN
  localparam int MAX_CNT = 2;
`else
  localparam int MAX_CNT = 1;
`endif

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        count;

  int checks   = 0;
  int failures = 0;

  logic [CTRL_W+DATA_W-1:0] exp_q[$];

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .count     (count)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;

    // ---------------- reset ----------------
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ctrl",  out_ctrl,  0);
    check("rst_out_data",  out_data,  0);
    check("rst_count",     count,     0);
    check("rst_in_ready",  in_ready,  1);

    // ---------------- streaming 1..4 ----------------
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_data = k;
      in_ctrl = 4'(k + 8);
      #1;
      check("stream_in_ready", in_ready, 1);
      step();
      check("stream_valid", out_valid, 1);
      check("stream_data",  out_data,  k);
      check("stream_ctrl",  out_ctrl,  k + 8);
      check("stream_count", count,     1);
    end
    in_valid = 1'b0;
    step();
    check("drain_valid", out_valid, 0);
    check("drain_ctrl",  out_ctrl,  0);
    check("drain_data_hold", out_data, 4);
    check("drain_count", count, 0);

    // ---------------- stall: 0xA then 0xB ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    in_ctrl   = 4'h5;
    step();
    check("stall_a_data",  out_data, 32'hA);
    check("stall_a_count", count, 1);
    in_data = 32'hB;
    in_ctrl = 4'h6;
`ifdef PIPE_STAGE_SKID_EN
    #1;
    check("stall_skid_in_ready_empty", in_ready, 1);
    step();
    check("stall_skid_count",    count,    2);
    check("stall_skid_in_ready", in_ready, 0);
    check("stall_skid_data",     out_data, 32'hA);
    step();
    check("stall_skid_hold_count", count,    2);
    check("stall_skid_hold_data",  out_data, 32'hA);
    check("stall_skid_hold_ctrl",  out_ctrl, 4'h5);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("release_a_data", out_data, 32'hA);
    step();
    check("release_b_data",     out_data, 32'hB);
    check("release_b_ctrl",     out_ctrl, 4'h6);
    check("release_b_count",    count,    1);
    check("release_in_ready",   in_ready, 1);
`else
    #1;
    check("stall_in_ready", in_ready, 0);
    step();
    check("stall_hold_data",  out_data, 32'hA);
    check("stall_hold_ctrl",  out_ctrl, 4'h5);
    check("stall_hold_count", count,    1);
    out_ready = 1'b1;
    #1;
    check("release_a_data",   out_data, 32'hA);
    check("release_in_ready", in_ready, 1);
    step();
    check("release_b_data",  out_data, 32'hB);
    check("release_b_ctrl",  out_ctrl, 4'h6);
    check("release_b_count", count,    1);
    in_valid = 1'b0;
`endif
    step();
    check("release_empty_valid", out_valid, 0);
    check("release_empty_ctrl",  out_ctrl,  0);

    // ---------------- flush ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    in_ctrl   = 4'h3;
    step();
`ifdef PIPE_STAGE_SKID_EN
    in_data = 32'h22;
    step();
    check("flush_pre_count", count, 2);
`else
    check("flush_pre_count", count, 1);
`endif
    in_data   = 32'h33;
    in_ctrl   = 4'hF;
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    check("flush_valid", out_valid, 0);
    check("flush_ctrl",  out_ctrl,  0);
    check("flush_count", count,     0);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    check("flush_after_valid", out_valid, 0);
    check("flush_after_count", count,     0);
    check("flush_after_in_ready", in_ready, 1);

    // ---------------- reset mid-stall ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD;
    in_ctrl   = 4'h2;
    step();
    check("rststall_count", count,    1);
    check("rststall_data",  out_data, 32'hDEAD);
    in_data = 32'hBEEF;
    rst     = 1'b1;
    flush   = 1'b1;
    step();
    check("rststall_valid",    out_valid, 0);
    check("rststall_data_clr", out_data,  0);
    check("rststall_ctrl",     out_ctrl,  0);
    check("rststall_count0",   count,     0);
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rststall_in_ready", in_ready, 1);
    step();
    check("rststall_after_valid", out_valid, 0);

    // ---------------- random against reference queue ----------------
    exp_q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      in_ctrl   = 4'($urandom_range(1, 15));
      #1;
      check("rand_count", count, exp_q.size());
      if (out_valid) begin
        check("rand_front", {out_ctrl, out_data}, exp_q[0]);
      end else begin
        check("rand_nop_ctrl", out_ctrl, 0);
      end
      if (count > MAX_CNT) check("rand_count_max", count, MAX_CNT);
      if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (out_valid) begin
        check("rand_drain_front", {out_ctrl, out_data}, exp_q[0]);
        void'(exp_q.pop_front());
      end
      step();
    end
    check("rand_final_count", count, 0);
    check("rand_final_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
